// File: rtl/udp_tx_rr_arbiter.sv
// udp_tx_rr_arbiter: packet-level round-robin arbiter that shares one 32-bit MAC TX stream
// among N frame generators. Requests are latched, one source owns the MAC per frame, its bus is
// forwarded with one registered cycle of latency, and stalled or runaway owners are revoked.
module udp_tx_rr_arbiter #(
  parameter int N        = 4,
  parameter int START_TO = 64,
  parameter int MAX_LEN  = 512,
  parameter int GAP      = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tx_rdy_i,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    src_wren_i,
  input  logic [N-1:0]    src_sop_i,
  input  logic [N-1:0]    src_eop_i,
  input  logic [2*N-1:0]  src_mod_i,
  input  logic [32*N-1:0] src_data_i,
  output logic [N-1:0]    src_rdy_o,
  output logic [N-1:0]    grant_o,
  output logic            tx_wren_o,
  output logic            tx_sop_o,
  output logic            tx_eop_o,
  output logic [1:0]      tx_mod_o,
  output logic [31:0]     tx_data_o,
  output logic            busy_o,
  output logic            to_err_o
);

  localparam int MAXC = (START_TO > MAX_LEN) ? START_TO : MAX_LEN;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int SW   = PW + 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOP,
    ST_XFER,
    ST_GAP
  } state_e;

  state_e         state_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [PW-1:0]  ptr_q, owner_q, ptr_next;
  logic [CW-1:0]  cnt_q, cnt_inc;
  logic [N-1:0]   grant_q, src_rdy_q;
  logic           tx_wren_q, tx_sop_q, tx_eop_q;
  logic [1:0]     tx_mod_q;
  logic [31:0]    tx_data_q;
  logic           busy_q, to_err_q;

  logic           pick_valid;
  logic [PW-1:0]  pick_idx;
  logic [SW-1:0]  cand_sum;
  logic [N-1:0]   pick_onehot;

  logic           own_wren, own_sop, own_eop;
  logic [1:0]     own_mod;
  logic [31:0]    own_data;

  // Current owner's bus slice; only meaningful while a source holds the grant.
  assign own_wren = src_wren_i[owner_q];
  assign own_sop  = src_sop_i[owner_q];
  assign own_eop  = src_eop_i[owner_q];
  assign own_mod  = src_mod_i[{owner_q, 1'b0} +: 2];
  assign own_data = src_data_i[{owner_q, 5'b0} +: 32];

  // The next round starts just after the source that is releasing, so it goes last next time.
  assign ptr_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  // The shared cycle counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  assign pick_onehot = ONE << pick_idx;

  // Round-robin search: the first pending source at or after the pointer, wrapping N-1 -> 0.
  // Walking from the farthest candidate back to the pointer leaves the nearest one selected.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_q} + SW'(k);
      if (cand_sum >= SW'(N)) cand_sum = cand_sum - SW'(N);
      if (pending_q[cand_sum[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_sum[PW-1:0];
      end
    end
  end

  // A source's pending bit drops only when it is granted; a request arriving that same cycle wins.
  always_comb begin
    pending_d = pending_q | req_i;
    if (state_q == ST_IDLE && pick_valid) pending_d = (pending_q & ~pick_onehot) | req_i;
  end

  // Latch request pulses so no request is lost while another source owns the MAC.
  always_ff @(posedge clk_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Arbitration FSM with registered grant, datapath mux, ready routing and timeout handling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      src_rdy_q <= '0;
      tx_wren_q <= 1'b0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_mod_q  <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          src_rdy_q <= '0;
          tx_wren_q <= 1'b0;
          tx_sop_q  <= 1'b0;
          tx_eop_q  <= 1'b0;
          tx_mod_q  <= '0;
          tx_data_q <= '0;
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= pick_onehot;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_SOP;
          end
        end

        ST_WAIT_SOP: begin
          src_rdy_q <= grant_q & {N{tx_rdy_i}};
          tx_wren_q <= own_wren;
          tx_sop_q  <= own_sop;
          tx_eop_q  <= own_eop;
          tx_mod_q  <= own_mod;
          tx_data_q <= own_data;
          cnt_q     <= cnt_inc;
          if (own_wren) begin
            if (own_eop) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              cnt_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              // The first word is already accepted, so the frame length count starts at one.
              cnt_q   <= CW'(1);
              state_q <= ST_XFER;
            end
          end else if (cnt_q == CW'(START_TO - 1)) begin
            grant_q  <= '0;
            ptr_q    <= ptr_next;
            cnt_q    <= '0;
            to_err_q <= 1'b1;
            state_q  <= ST_GAP;
          end
        end

        ST_XFER: begin
          src_rdy_q <= grant_q & {N{tx_rdy_i}};
          tx_wren_q <= own_wren;
          tx_sop_q  <= own_sop;
          tx_eop_q  <= own_eop;
          tx_mod_q  <= own_mod;
          tx_data_q <= own_data;
          cnt_q     <= cnt_inc;
          if (own_wren && own_eop) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else if (cnt_q >= CW'(MAX_LEN - 1)) begin
            // Replace this cycle's word with a closing eop so the MAC frame is terminated cleanly.
            tx_wren_q <= 1'b1;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b1;
            tx_mod_q  <= '0;
            grant_q   <= '0;
            ptr_q     <= ptr_next;
            cnt_q     <= '0;
            to_err_q  <= 1'b1;
            state_q   <= ST_GAP;
          end
        end

        ST_GAP: begin
          src_rdy_q <= '0;
          grant_q   <= '0;
          tx_wren_q <= 1'b0;
          tx_sop_q  <= 1'b0;
          tx_eop_q  <= 1'b0;
          tx_mod_q  <= '0;
          tx_data_q <= '0;
          cnt_q     <= cnt_inc;
          if (cnt_q >= CW'(GAP - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_rdy_o = src_rdy_q;
  assign grant_o   = grant_q;
  assign tx_wren_o = tx_wren_q;
  assign tx_sop_o  = tx_sop_q;
  assign tx_eop_o  = tx_eop_q;
  assign tx_mod_o  = tx_mod_q;
  assign tx_data_o = tx_data_q;
  assign busy_o    = busy_q;
  assign to_err_o  = to_err_q;

endmodule

// File: tb/tb_udp_tx_rr_arbiter.sv
// tb_udp_tx_rr_arbiter: table of request patterns with their expected service order, plus hand
// sequences for start timeout, max-length cut, ready routing, fairness and mid-frame reset.
module tb_udp_tx_rr_arbiter;

  localparam int N        = 4;
  localparam int START_TO = 64;
  localparam int MAX_LEN  = 512;
  localparam int GAP      = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            txRdy;
  logic [N-1:0]    req, srcWren, srcSop, srcEop;
  logic [2*N-1:0]  srcMod;
  logic [32*N-1:0] srcData;
  logic [N-1:0]    srcRdy, grant;
  logic            txWren, txSop, txEop;
  logic [1:0]      txMod;
  logic [31:0]     txData;
  logic            busy, toErr;

  udp_tx_rr_arbiter #(.N(N), .START_TO(START_TO), .MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .tx_rdy_i(txRdy), .req_i(req),
    .src_wren_i(srcWren), .src_sop_i(srcSop), .src_eop_i(srcEop),
    .src_mod_i(srcMod), .src_data_i(srcData),
    .src_rdy_o(srcRdy), .grant_o(grant),
    .tx_wren_o(txWren), .tx_sop_o(txSop), .tx_eop_o(txEop),
    .tx_mod_o(txMod), .tx_data_o(txData), .busy_o(busy), .to_err_o(toErr)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  int checkCount = 0;
  int passCount  = 0;
  int frameId    = 0;

  // Free-running cycle count used to check the one-cycle forwarding latency.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
    logic        chkData;
    int          cyc;
  } expWord_t;

  expWord_t sbQ[$];
  expWord_t monExp;

  typedef struct {
    logic [N-1:0]    reqMask;
    int              len;
    logic [3:0][1:0] order;
    int              nServe;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleCount);
  endtask

  // Every MAC write must match the oldest expected word, arriving exactly one cycle after it was driven.
  always @(negedge clk) begin
    if (txWren === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("txUnexpected", 32'd1, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("txCtl", {27'd0, txSop, txEop, txMod, toErr},
                    {27'd0, monExp.sop, monExp.eop, monExp.mod, monExp.err});
        checkOutput("txLatency", 32'(cycleCount), 32'(monExp.cyc));
        if (monExp.chkData) checkOutput("txData", txData, monExp.data);
      end
    end
  end

  task automatic clearSources();
    srcWren = '0; srcSop = '0; srcEop = '0; srcMod = '0; srcData = '0; req = '0;
  endtask

  task automatic doReset();
    checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; clearSources(); txRdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask);
    @(posedge clk); #1; req = mask;
    @(posedge clk); #1; req = '0;
  endtask

  task automatic waitGrant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant !== '0) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("grantWait", 32'd0, 32'd1);
  endtask

  task automatic pushWord(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m,
                          input logic err, input logic chk);
    expWord_t w;
    w.data = d; w.sop = s; w.eop = e; w.mod = m; w.err = err; w.chkData = chk;
    w.cyc = cycleCount + 1;
    sbQ.push_back(w);
  endtask

  // Owner streams a frame while the other sources drive random noise that must never reach the MAC.
  task automatic sendFrame(input int s, input int len, input logic [N-1:0] reqLast);
    logic [31:0] d;
    logic [1:0]  m;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      srcWren = N'($urandom); srcSop = N'($urandom); srcEop = N'($urandom);
      srcMod  = (2*N)'($urandom);
      srcData = {$urandom, $urandom, $urandom, $urandom};
      d = {8'(s), 8'(frameId), 16'(i)};
      m = (i == len - 1) ? 2'(i) : 2'd0;
      srcWren[s] = 1'b1;
      srcSop[s]  = (i == 0);
      srcEop[s]  = (i == len - 1);
      srcMod[2*s +: 2]   = m;
      srcData[32*s +: 32] = d;
      req = (i == len - 1) ? reqLast : '0;
      pushWord(d, (i == 0), (i == len - 1), m, 1'b0, 1'b1);
    end
    frameId++;
    @(posedge clk); #1;
    clearSources();
  endtask

  task automatic serveOne(input int expSrc, input int len, input logic [N-1:0] reqLast);
    bit ok;
    logic [N-1:0] expGrant;
    expGrant = '0;
    expGrant[expSrc] = 1'b1;
    waitGrant(200, ok);
    if (!ok) return;
    checkOutput("grantOneHot", 32'(grant), 32'(expGrant));
    checkOutput("busyOwned", 32'(busy), 32'd1);
    sendFrame(expSrc, len, reqLast);
    @(negedge clk);
    checkOutput("gapGrant", 32'({busy, grant}), 32'({1'b1, {N{1'b0}}}));
    @(negedge clk);
    checkOutput("gapIdleBus", 32'({busy, grant, txWren}), 32'({1'b1, {N{1'b0}}, 1'b0}));
    @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);
  endtask

  // Global time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checkCount);
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    bit ok;
    bit holdOk;
    logic [7:0] pat;
    logic prev;
    logic [31:0] d;

    rst = 1'b1; txRdy = 1'b1; clearSources();

    vecs[0] = '{4'b0001, 4, {2'd0, 2'd0, 2'd0, 2'd0}, 1};
    vecs[1] = '{4'b1011, 3, {2'd0, 2'd3, 2'd1, 2'd0}, 3};
    vecs[2] = '{4'b0110, 1, {2'd0, 2'd0, 2'd2, 2'd1}, 2};
    vecs[3] = '{4'b1111, 2, {2'd3, 2'd2, 2'd1, 2'd0}, 4};
    vecs[4] = '{4'b1100, 5, {2'd0, 2'd0, 2'd3, 2'd2}, 2};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetState", 32'({grant, srcRdy, txWren, txSop, txEop, txMod, busy, toErr}), 32'd0);

    for (int i = 0; i < 5; i++) begin
      doReset();
      applyStimulus(vecs[i].reqMask);
      for (int j = 0; j < vecs[i].nServe; j++) serveOne(int'(vecs[i].order[j]), vecs[i].len, '0);
    end

    // Source 0 re-requests on its own eop cycle and must wait behind source 1.
    doReset();
    applyStimulus(4'b0011);
    serveOne(0, 3, 4'b0001);
    serveOne(1, 2, '0);
    serveOne(0, 2, '0);

    // Source 2 never starts: grant revoked after START_TO cycles, then source 3 is served.
    doReset();
    applyStimulus(4'b1100);
    waitGrant(50, ok);
    checkOutput("toGrant", 32'(grant), 32'(4'b0100));
    holdOk = 1'b1;
    repeat (START_TO - 1) begin
      @(negedge clk);
      if (grant !== 4'b0100 || toErr !== 1'b0) holdOk = 1'b0;
    end
    checkOutput("waitSopHold", 32'(holdOk), 32'd1);
    @(negedge clk);
    checkOutput("timeoutGrant", 32'(grant), 32'd0);
    checkOutput("timeoutErr", 32'(toErr), 32'd1);
    @(negedge clk);
    checkOutput("timeoutPulse", 32'(toErr), 32'd0);
    serveOne(3, 3, '0);

    // Source 1 streams 600 words with no eop: word 512 becomes a forced eop, the rest is dropped.
    doReset();
    applyStimulus(4'b0010);
    waitGrant(50, ok);
    checkOutput("maxGrant", 32'(grant), 32'(4'b0010));
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      d = {8'd1, 8'hAA, 16'(i)};
      srcWren[1] = 1'b1;
      srcSop[1]  = (i == 0);
      srcData[63:32] = d;
      if (i < MAX_LEN - 1) pushWord(d, (i == 0), 1'b0, 2'd0, 1'b0, 1'b1);
      else if (i == MAX_LEN - 1) pushWord(d, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    clearSources();
    @(negedge clk);
    checkOutput("maxRelease", 32'({busy, grant}), 32'd0);

    // tx_rdy toggles while source 0 owns the MAC; only src_rdy[0] follows, one cycle later.
    doReset();
    applyStimulus(4'b0001);
    waitGrant(50, ok);
    pat  = 8'b0110_1001;
    prev = txRdy;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      txRdy = pat[k];
      @(negedge clk);
      checkOutput("srcRdy", 32'(srcRdy), 32'({3'b000, prev}));
      prev = pat[k];
    end
    txRdy = 1'b1;
    sendFrame(0, 2, '0);
    repeat (4) @(negedge clk);

    // Reset mid-frame after the pointer has moved: everything clears and old requests are forgotten.
    doReset();
    applyStimulus(4'b0100);
    serveOne(2, 2, '0);
    applyStimulus(4'b0011);
    waitGrant(50, ok);
    checkOutput("preRstGrant", 32'(grant), 32'(4'b0001));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      d = {8'd0, 8'h55, 16'(i)};
      srcWren[0] = 1'b1;
      srcSop[0]  = (i == 0);
      srcData[31:0] = d;
      pushWord(d, (i == 0), 1'b0, 2'd0, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1; clearSources();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstCtl", 32'({grant, srcRdy, txWren, txSop, txEop, txMod, busy, toErr}), 32'd0);
    checkOutput("rstData", txData, 32'd0);
    holdOk = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (grant !== '0 || busy !== 1'b0) holdOk = 1'b0;
    end
    checkOutput("rstPendingCleared", 32'(holdOk), 32'd1);
    applyStimulus(4'b1010);
    serveOne(1, 2, '0);
    serveOne(3, 2, '0);

    repeat (5) @(negedge clk);
    checkOutput("sbDrainFinal", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
